// File: rtl/aes_core_arbiter.sv
// ============================================================================
// Module  : aes_core_arbiter
// Brief   : Round-robin sharing of one AES core between two requesters,
//           with per-request watchdog and result routing to the granted port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_core_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 16
) (
    input  logic         i_Clk,
    input  logic         i_Rst,

    input  logic         i_fReq0,
    input  logic         i_fDec0,
    input  logic [127:0] i_Key0,
    input  logic [127:0] i_Text0,
    output logic         o_fAck0,
    output logic         o_fDone0,
    output logic         o_fErr0,
    output logic [127:0] o_Text0,

    input  logic         i_fReq1,
    input  logic         i_fDec1,
    input  logic [127:0] i_Key1,
    input  logic [127:0] i_Text1,
    output logic         o_fAck1,
    output logic         o_fDone1,
    output logic         o_fErr1,
    output logic [127:0] o_Text1,

    output logic         o_fStart,
    output logic         o_fDec,
    output logic [127:0] o_Key,
    output logic [127:0] o_Text,
    input  logic         i_fDone,
    input  logic [127:0] i_Text,
    output logic         o_fBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic          rr_ptr;
    logic          grant_id;
    logic [TW-1:0] timer;
    logic          pick1;

    // Port 1 wins when it is the only requester, or on a tie when it is favoured.
    always_comb begin
        pick1 = i_fReq1 & (~i_fReq0 | rr_ptr);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            grant_id <= 1'b0;
            timer    <= '0;
            o_fAck0  <= 1'b0;
            o_fDone0 <= 1'b0;
            o_fErr0  <= 1'b0;
            o_Text0  <= '0;
            o_fAck1  <= 1'b0;
            o_fDone1 <= 1'b0;
            o_fErr1  <= 1'b0;
            o_Text1  <= '0;
            o_fStart <= 1'b0;
            o_fDec   <= 1'b0;
            o_Key    <= '0;
            o_Text   <= '0;
            o_fBusy  <= 1'b0;
        end else begin
            o_fAck0  <= 1'b0;
            o_fAck1  <= 1'b0;
            o_fStart <= 1'b0;
            o_fDone0 <= 1'b0;
            o_fDone1 <= 1'b0;
            o_fErr0  <= 1'b0;
            o_fErr1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_fReq0 | i_fReq1) begin
                        grant_id <= pick1;
                        o_fDec   <= pick1 ? i_fDec1 : i_fDec0;
                        o_Key    <= pick1 ? i_Key1  : i_Key0;
                        o_Text   <= pick1 ? i_Text1 : i_Text0;
                        o_fAck0  <= ~pick1;
                        o_fAck1  <= pick1;
                        o_fStart <= 1'b1;
                        o_fBusy  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A completion on the watchdog's last cycle still counts as success.
                    if (i_fDone) begin
                        if (grant_id) begin
                            o_Text1  <= i_Text;
                            o_fDone1 <= 1'b1;
                        end else begin
                            o_Text0  <= i_Text;
                            o_fDone0 <= 1'b1;
                        end
                        rr_ptr  <= ~grant_id;
                        o_fBusy <= 1'b0;
                        state   <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        o_fErr0 <= ~grant_id;
                        o_fErr1 <= grant_id;
                        rr_ptr  <= ~grant_id;
                        o_fBusy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_fBusy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares a single AES core between two independent requesters (port 0, port 1) with round-robin arbitration.
- Captures the winning request's key, text and direction, then sequences the core through start, wait-for-done and result return.
- Routes the core result back to the granted requester only.
- Provides a per-request watchdog so a hung core cannot deadlock either requester.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before the request is aborted with an error pulse (legal range 2..65535).
- TW, 16, timeout counter width in bits (must satisfy 2^TW > TIMEOUT).

Ports:
- i_Clk  in  1  clock, rising edge
- i_Rst  in  1  asynchronous, active-high reset
- i_fReq0  in  1  port 0 request; hold high with data stable until o_fAck0
- i_fDec0  in  1  port 0 direction: 1 = decrypt, 0 = encrypt
- i_Key0  in  128  port 0 key
- i_Text0  in  128  port 0 input block
- o_fAck0  out  1  one-cycle pulse: port 0 request accepted
- o_fDone0  out  1  one-cycle pulse: o_Text0 valid
- o_fErr0  out  1  one-cycle pulse: port 0 request timed out
- o_Text0  out  128  port 0 result, held until the next port 0 completion
- i_fReq1, i_fDec1, i_Key1, i_Text1, o_fAck1, o_fDone1, o_fErr1, o_Text1: same as port 0, for port 1
- o_fStart  out  1  core start pulse, one cycle
- o_fDec  out  1  core direction
- o_Key  out  128  core key
- o_Text  out  128  core input block
- i_fDone  in  1  core completion
- i_Text  in  128  core output block
- o_fBusy  out  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered. On reset, every output is 0, state = IDLE, rr_ptr = 0 (port 0 favoured) and timer = 0. Reset is honoured in any state, including mid-operation; core output arriving after reset is ignored.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - If any i_fReqN is high, grant by round-robin. When only one port requests, grant it. When both request, grant port rr_ptr.
  - On the grant edge: load o_Key, o_Text and o_fDec from the granted port; set o_fAckN=1 and o_fStart=1; store grant_id; move to START.
- START: lasts exactly one cycle. o_fAckN and o_fStart are each high for exactly this cycle. Next edge: drop both, clear timer, move to WAIT.
- WAIT: timer increments every cycle.
  - If i_fDone=1: o_Text<grant_id> <= i_Text, o_fDone<grant_id>=1 for one cycle, rr_ptr <= ~grant_id, move to IDLE.
  - Else if timer == TIMEOUT-1: o_fErr<grant_id>=1 for one cycle, rr_ptr <= ~grant_id, move to IDLE. The result register is unchanged.
  - i_fDone and timeout on the same edge: done wins and no error is signalled.
- i_fDone outside WAIT is ignored. This covers a late done after a timeout.
- Latency:
  - Request sampled at edge k in IDLE gives ack/start high in cycle k..k+1.
  - Core done sampled at edge d gives o_fDoneN high in cycle d..d+1.
  - After completion, a new grant is possible at edge d+1 at the earliest.
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1...
- A requester may deassert i_fReqN only after o_fAckN. o_Key, o_Text and o_fDec are held constant from START until the next grant.

Test Plan:
1. Reset, then port 0 encrypts with Key=70337336763979244226452948404D63, Text=566B59703273357638792F423F452848 -> o_fAck0 and o_fStart pulse once, then o_fDone0 pulse with o_Text0=71a4d5f1009b926a22428735dd77a40c; port 1 outputs stay 0.
2. Port 1 decrypts with the same key and Text=71a4d5f1009b926a22428735dd77a40c -> o_Text1=566B59703273357638792F423F452848; o_Text0 remains unchanged.
3. Both ports request continuously for 4 transactions -> grant order 0,1,0,1; exactly one o_fStart per grant; o_fBusy drops for exactly one cycle between transactions.
4. Core model never asserts i_fDone, TIMEOUT=8 -> o_fErr0 pulses 8 cycles after entering WAIT, FSM returns to IDLE, o_Text0 is unchanged; a later spurious i_fDone is ignored.
5. i_fDone and timeout on the same edge -> o_fDone pulses and o_fErr stays 0.
6. Assert i_Rst during WAIT -> all outputs return to 0 immediately (asynchronously); the following i_fDone produces no o_fDone; the next request is granted to port 0.
